// File: rtl/wts_envelope_generator.sv
// rtl/wts_envelope_generator.sv - per-channel ADSR envelope generator for the wave table engine
module wts_envelope_generator (
   input  logic       clk,
   input  logic       nreset,
   input  logic       tick,
   input  logic       key_on,
   input  logic       reg_env_enable,
   input  logic [3:0] reg_attack,
   input  logic [3:0] reg_decay,
   input  logic [3:0] reg_sustain,
   input  logic [3:0] reg_release,
   output logic [8:0] envelope,
   output logic       busy
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ATTACK  = 3'd1;
   localparam logic [2:0] ST_DECAY   = 3'd2;
   localparam logic [2:0] ST_SUSTAIN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   logic [2:0]  state, state_nx;
   logic [7:0]  level, level_nx;
   logic [13:0] cnt, cnt_nx;
   logic        gate_d;

   logic        rise, fall;
   logic [3:0]  rate;
   logic [13:0] limit;
   logic        step_due;
   logic [7:0]  sus_level;
   logic [7:0]  level_dec;
   logic [13:0] cnt_inc;

   assign rise      = key_on & ~gate_d;
   assign fall      = ~key_on & gate_d;
   assign sus_level = {reg_sustain, reg_sustain};
   assign level_dec = level - 8'd1;
   assign cnt_inc   = cnt + 14'd1;

   always_comb begin
      rate = 4'd0;
      case (state)
         ST_ATTACK:  rate = reg_attack;
         ST_DECAY:   rate = reg_decay;
         ST_RELEASE: rate = reg_release;
         default:    rate = 4'd0;
      endcase
   end

   // Period 2^(r-1) ticks; >= lets a shortened rate take effect on the next tick.
   assign limit    = 14'h3FFF >> (4'd15 - rate);
   assign step_due = (cnt >= limit);

   always_comb begin
      state_nx = state;
      level_nx = level;
      cnt_nx   = cnt;
      if (rise) begin
         state_nx = ST_ATTACK;
         cnt_nx   = '0;
      end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
         state_nx = ST_RELEASE;
         cnt_nx   = '0;
      end else if (tick) begin
         case (state)
            ST_ATTACK: begin
               if (level == 8'hFF || rate == 4'd0) begin
                  level_nx = 8'hFF;
                  state_nx = ST_DECAY;
                  cnt_nx   = '0;
               end else if (step_due) begin
                  level_nx = level + 8'd1;
                  cnt_nx   = '0;
                  if (level == 8'hFE) begin
                     state_nx = ST_DECAY;
                  end
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            ST_DECAY: begin
               if (level <= sus_level || rate == 4'd0) begin
                  level_nx = sus_level;
                  state_nx = ST_SUSTAIN;
                  cnt_nx   = '0;
               end else if (step_due) begin
                  cnt_nx = '0;
                  if (level_dec <= sus_level) begin
                     level_nx = sus_level;
                     state_nx = ST_SUSTAIN;
                  end else begin
                     level_nx = level_dec;
                  end
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            ST_SUSTAIN: begin
               level_nx = sus_level;
            end
            ST_RELEASE: begin
               if (level == 8'h00 || rate == 4'd0) begin
                  level_nx = 8'h00;
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end else if (step_due) begin
                  level_nx = level_dec;
                  cnt_nx   = '0;
                  if (level == 8'h01) begin
                     state_nx = ST_IDLE;
                  end
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
            default: begin
               state_nx = state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= ST_IDLE;
         level    <= 8'h00;
         cnt      <= '0;
         gate_d   <= 1'b0;
         envelope <= 9'h000;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         level    <= level_nx;
         cnt      <= cnt_nx;
         gate_d   <= key_on;
         // Output reflects the level from before this edge: one clock behind the step.
         envelope <= reg_env_enable ? {1'b0, level} : 9'h1FF;
         busy     <= (state != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_wts_envelope_generator.sv
// tb/tb_wts_envelope_generator.sv - directed self-checking bench for wts_envelope_generator
module tb_wts_envelope_generator;

   logic       clk;
   logic       nreset;
   logic       tick;
   logic       key_on;
   logic       reg_env_enable;
   logic [3:0] reg_attack;
   logic [3:0] reg_decay;
   logic [3:0] reg_sustain;
   logic [3:0] reg_release;
   logic [8:0] envelope;
   logic       busy;

   int checks;
   int errors;

   wts_envelope_generator dut (
      .clk            (clk),
      .nreset         (nreset),
      .tick           (tick),
      .key_on         (key_on),
      .reg_env_enable (reg_env_enable),
      .reg_attack     (reg_attack),
      .reg_decay      (reg_decay),
      .reg_sustain    (reg_sustain),
      .reg_release    (reg_release),
      .envelope       (envelope),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0; tick = 1'b1; key_on = 1'b0; reg_env_enable = 1'b1;
      reg_attack = 4'd1; reg_decay = 4'd2; reg_sustain = 4'd8; reg_release = 4'd0;
      cyc(); cyc();
      checks++;
      if (envelope !== 9'h000) begin errors++; $display("FAIL reset_env: got %h expected 000", envelope); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      nreset = 1'b1;
   endtask

   task automatic test_attack();
      key_on = 1'b1;
      cyc();
      checks++;
      if (busy !== 1'b0 || envelope !== 9'h000) begin
         errors++; $display("FAIL attack_edge: got busy=%b env=%h expected busy=0 env=000", busy, envelope);
      end
      cyc();
      checks++;
      if (busy !== 1'b1 || envelope !== 9'h000) begin
         errors++; $display("FAIL attack_busy: got busy=%b env=%h expected busy=1 env=000", busy, envelope);
      end
      for (int i = 1; i <= 255; i++) begin
         cyc();
         checks++;
         if (envelope !== 9'(i)) begin errors++; $display("FAIL attack_ramp: got %h expected %h", envelope, 9'(i)); end
      end
   endtask

   task automatic test_decay_sustain();
      for (int j = 1; j <= 119; j++) begin
         cyc(); cyc();
         checks++;
         if (envelope !== 9'(255 - j)) begin errors++; $display("FAIL decay_step: got %h expected %h", envelope, 9'(255 - j)); end
      end
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++;
         if (envelope !== 9'h088 || busy !== 1'b1) begin
            errors++; $display("FAIL sustain_hold: got busy=%b env=%h expected busy=1 env=088", busy, envelope);
         end
      end
   endtask

   task automatic test_release();
      key_on = 1'b0; reg_release = 4'd0;
      cyc();
      cyc();
      checks++;
      if (envelope !== 9'h088 || busy !== 1'b1) begin
         errors++; $display("FAIL release_pre: got busy=%b env=%h expected busy=1 env=088", busy, envelope);
      end
      cyc();
      checks++;
      if (envelope !== 9'h000 || busy !== 1'b0) begin
         errors++; $display("FAIL release_fast: got busy=%b env=%h expected busy=0 env=000", busy, envelope);
      end
   endtask

   task automatic test_rekey();
      reg_attack = 4'd0; reg_decay = 4'd0; reg_sustain = 4'hF; reg_release = 4'd2;
      key_on = 1'b1;
      repeat (4) cyc();
      checks++;
      if (envelope !== 9'h0FF) begin errors++; $display("FAIL rekey_peak: got %h expected 0ff", envelope); end
      key_on = 1'b0;
      repeat (384) cyc();
      checks++;
      if (envelope !== 9'h040) begin errors++; $display("FAIL rekey_rel40: got %h expected 040", envelope); end
      key_on = 1'b1; reg_attack = 4'd3;
      cyc();
      checks++;
      if (envelope !== 9'h040) begin errors++; $display("FAIL rekey_edge: got %h expected 040", envelope); end
      for (int m = 1; m <= 9; m++) begin
         cyc();
         checks++;
         if (envelope !== 9'(8'h40 + (m - 1) / 4)) begin
            errors++; $display("FAIL rekey_attack m=%0d: got %h expected %h", m, envelope, 9'(8'h40 + (m - 1) / 4));
         end
      end
   endtask

   task automatic test_bypass();
      reg_env_enable = 1'b0;
      for (int m = 10; m <= 20; m++) begin
         cyc();
         checks++;
         if (envelope !== 9'h1FF) begin errors++; $display("FAIL bypass m=%0d: got %h expected 1ff", m, envelope); end
      end
      reg_env_enable = 1'b1;
      cyc();
      checks++;
      if (envelope !== 9'h045) begin errors++; $display("FAIL reenable: got %h expected 045", envelope); end
   endtask

   task automatic test_gate_tick();
      cyc(); cyc();
      checks++;
      if (envelope !== 9'h045) begin errors++; $display("FAIL gate_tick_pre: got %h expected 045", envelope); end
      key_on = 1'b0; reg_release = 4'd1;
      cyc();
      cyc();
      checks++;
      if (envelope !== 9'h045) begin errors++; $display("FAIL gate_tick_nostep: got %h expected 045", envelope); end
      cyc();
      checks++;
      if (envelope !== 9'h044) begin errors++; $display("FAIL gate_tick_release: got %h expected 044", envelope); end
   endtask

   task automatic test_async_reset();
      key_on = 1'b1; reg_attack = 4'd0; reg_decay = 4'd4; reg_sustain = 4'd0;
      repeat (4) cyc();
      checks++;
      if (envelope !== 9'h0FF || busy !== 1'b1) begin
         errors++; $display("FAIL mid_decay: got busy=%b env=%h expected busy=1 env=0ff", busy, envelope);
      end
      nreset = 1'b0;
      #2;
      checks++;
      if (envelope !== 9'h000 || busy !== 1'b0) begin
         errors++; $display("FAIL async_reset: got busy=%b env=%h expected busy=0 env=000", busy, envelope);
      end
      cyc();
      nreset = 1'b1;
      cyc();
      checks++;
      if (envelope !== 9'h000 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_edge: got busy=%b env=%h expected busy=0 env=000", busy, envelope);
      end
      cyc();
      checks++;
      if (envelope !== 9'h000 || busy !== 1'b1) begin
         errors++; $display("FAIL post_reset_busy: got busy=%b env=%h expected busy=1 env=000", busy, envelope);
      end
      cyc();
      checks++;
      if (envelope !== 9'h0FF) begin errors++; $display("FAIL post_reset_attack: got %h expected 0ff", envelope); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_attack();
      test_decay_sustain();
      test_release();
      test_rekey();
      test_bypass();
      test_gate_tick();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wts_envelope_generator.md
# wts_envelope_generator

Per-channel envelope generator for the wave table sound engine. Produces the 9-bit `envelope` word consumed by the channel volume stage: bit 8 set means "envelope bypassed, pass wave through unscaled"; bits 7:0 are an unsigned attenuation level, 0x00 silent to 0xFF full. It runs a four-phase attack/decay/sustain/release state machine, paced by a shared timebase tick and gated by the channel's key-on register bit.

## Interface
- No parameters.
- `clk` input 1: system clock.
- `nreset` input 1: reset, asynchronous, active-low.
- `tick` input 1: one-cycle timebase enable, shared by all channels.
- `key_on` input 1: gate level from the register file; 1 means note held.
- `reg_env_enable` input 1: 1 applies the envelope; 0 bypasses it.
- `reg_attack` input 4: attack rate code.
- `reg_decay` input 4: decay rate code.
- `reg_sustain` input 4: sustain level code.
- `reg_release` input 4: release rate code.
- `envelope` output 9: registered envelope word to the volume stage.
- `busy` output 1: registered; 1 when state is not IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Internal `level` is 8 bits unsigned. There is a 14-bit step counter `cnt` and a registered copy `gate_d` of `key_on`.
- Rising gate (`key_on`=1, `gate_d`=0): from any state go to ATTACK. `level` is kept, not cleared. `cnt` is cleared.
- Falling gate (`key_on`=0, `gate_d`=1): from ATTACK, DECAY or SUSTAIN go to RELEASE. `cnt` is cleared. In IDLE, nothing happens.
- Rate code r for the current phase (attack, decay or release):
  - r=0: on the next `tick`, `level` jumps straight to the phase target.
  - r=1..15: step period is 2^(r-1) ticks (1 to 16384).
  - On each `tick`: if `cnt` = 2^(r-1)-1, then step `level` by 1 and clear `cnt`; otherwise increment `cnt`.
- Sustain target S = {reg_sustain, reg_sustain}, so code 0 gives 0x00 and code 0xF gives 0xFF.
- ATTACK: step is +1. When `level` reaches 0xFF (after the step, or already there), go to DECAY with `cnt` cleared.
- DECAY: step is -1. When `level` <= S, force `level`=S and go to SUSTAIN. If S=0xFF this happens on the first tick in DECAY.
- SUSTAIN: `level` is held at S. A change to `reg_sustain` takes effect at the next `tick` and snaps `level` to the new S.
- RELEASE: step is -1. When `level` reaches 0, go to IDLE.
- IDLE: `level` is held and no stepping occurs.
- Arithmetic saturates: `level` never wraps past 0x00 or 0xFF.
- Register changes to rate codes are picked up at the next comparison. `cnt` is not cleared; if `cnt` already exceeds the new limit, the next `tick` steps and clears it.
- Output word, registered every cycle:
  - `reg_env_enable`=1: `envelope` = {1'b0, level}.
  - `reg_env_enable`=0: `envelope` = 9'h1FF. The state machine keeps running underneath.

## Timing
- Reset values: state IDLE, `level` 0x00, `cnt` 0, `gate_d` 0, `envelope` 9'h000, `busy` 0.
- The first clock after reset release loads `envelope` from `reg_env_enable` and `level`.
- A gate edge is acted on at the clock edge where `key_on` differs from `gate_d`. The state change is visible internally after that edge. `envelope` and `busy` reflect it one clock later.
- A level step happens at the clock edge where `tick`=1. `envelope` shows the new level one clock later, so latency from tick to output is 1 clock.
- Gate edge coinciding with `tick`: the edge wins. The state changes, `cnt` is cleared, and no step is taken that cycle.
- Phase-completion transitions happen at the same edge as the final step. The next phase starts counting at the following `tick`.
- Reset mid-operation: asynchronous, returns everything to the reset values immediately. There is no pending-edge memory, so a held `key_on` after reset is seen as a rising edge.
- Throughput: at most one step per `tick`. With `tick` constant 1 and r=1, `level` changes every clock.

## Test plan
- Reset, `key_on`=1, attack=1, `tick` every clock: `envelope` ramps 0x001..0x0FF over 255 ticks, `busy`=1 one clock after the edge.
- Decay=2, sustain=0x8, from peak: `level` falls by 1 every 2 ticks to 0x88, then holds in SUSTAIN with `envelope`=0x088.
- Drop `key_on` in SUSTAIN, release=0: next tick gives `envelope`=0x000, state IDLE, `busy`=0 one clock later.
- Re-key during RELEASE at `level`=0x40, attack=3: ATTACK resumes from 0x40 and steps every 4 ticks; `cnt` cleared at the edge.
- `reg_env_enable`=0 mid-attack: `envelope`=0x1FF next clock. Re-enable: shows the current `level`, which has advanced meanwhile.
- Gate edge and `tick` in the same cycle: no step taken. Assert `nreset` mid-decay: `envelope`=0x000 and `busy`=0 immediately.
